// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard / debug sequencing controller.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN    = 2'd0;
    localparam state_t ST_DRAIN  = 2'd1;
    localparam state_t ST_HALTED = 2'd2;
    localparam state_t ST_STEP   = 2'd3;

endpackage

// File: rtl/pipeline_hazard_ctrl_counter.sv
// Wrapping event counter with synchronous clear that beats increment.
module hazard_event_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing: load-use bubble, MEM-stage redirect squash, debug halt/step FSM
// and stall/redirect event counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_memread,
    input  logic                 mem_redirect,
    input  logic                 halt_req,
    input  logic                 step_req,
    input  logic                 cnt_clr,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic                 halted,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     redirect_cnt
);

    localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);

    state_t        state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          halted_q;
    logic          lu;

    assign lu = ex_memread & (ex_rd != '0) &
                ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (!halt_req) begin
                    state_d = ST_RUN;
                    drain_d = '0;
                end else if (drain_q <= DW'(1)) begin
                    state_d = ST_HALTED;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            ST_HALTED: begin
                if (!halt_req) begin
                    state_d = ST_RUN;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                // A load-use hazard holds the step until the one instruction can issue.
                if (!lu) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            default: begin
                state_d = ST_RUN;
                drain_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            drain_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            halted_q <= (state_d == ST_HALTED);
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if ((state_q == ST_DRAIN) || (state_q == ST_HALTED)) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
        if (lu) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
        if (mem_redirect) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
        end
    end

    assign halted = halted_q;

    hazard_event_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (lu & ~mem_redirect),
        .clr  (cnt_clr),
        .count(stall_cnt)
    );

    hazard_event_counter #(
        .CNT_W(CNT_W)
    ) u_redirect_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (mem_redirect),
        .clr  (cnt_clr),
        .count(redirect_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table plus halt/step/reset sequences.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs2, ex_memread, mem_redirect;
    logic        halt_req, step_req, cnt_clr;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, halted;
    logic [31:0] stall_cnt, redirect_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_stall, exp_redir;

    pipeline_hazard_ctrl #(
        .CNT_W       (32),
        .DRAIN_CYCLES(3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_memread  (ex_memread),
        .mem_redirect(mem_redirect),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .cnt_clr     (cnt_clr),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .ex_mem_flush(ex_mem_flush),
        .halted      (halted),
        .stall_cnt   (stall_cnt),
        .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       memread;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs2;
        logic       redirect;
        logic       e_pc;
        logic       e_ifid_wr;
        logic       e_ifid_fl;
        logic       e_idex_fl;
        logic       e_exmem_fl;
        logic       e_stall_inc;
        logic       e_redir_inc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                          input logic [4:0] r2, input logic u2, input logic redir);
        ex_memread   = mr;
        ex_rd        = rd;
        id_rs1       = r1;
        id_rs2       = r2;
        id_uses_rs2  = u2;
        mem_redirect = redir;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_freeze(input string name);
        @(negedge clk);
        chk({name, ".pc_write"}, 32'(pc_write), 32'd0);
        chk({name, ".id_ex_flush"}, 32'(id_ex_flush), 32'd1);
    endtask

    initial begin
        vecs[0] = '{"idle",        0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        vecs[1] = '{"lu_rs1",      1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        vecs[2] = '{"lu_rd0",      1, 5'd0, 5'd0, 5'd0, 1, 0, 1, 1, 0, 0, 0, 0, 0};
        vecs[3] = '{"rs2_unused",  1, 5'd7, 5'd1, 5'd7, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        vecs[4] = '{"rs2_used",    1, 5'd7, 5'd1, 5'd7, 1, 0, 0, 0, 0, 1, 0, 1, 0};
        vecs[5] = '{"no_load",     0, 5'd5, 5'd5, 5'd5, 1, 0, 1, 1, 0, 0, 0, 0, 0};
        vecs[6] = '{"redir_lu",    1, 5'd5, 5'd5, 5'd0, 0, 1, 1, 0, 1, 1, 1, 0, 1};
        vecs[7] = '{"redir_only",  0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 1, 1, 1, 0, 1};

        reset = 1'b1;
        halt_req = 1'b0;
        step_req = 1'b0;
        cnt_clr = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        #2;
        chk("rst.pc_write", 32'(pc_write), 32'd0);
        chk("rst.if_id_write", 32'(if_id_write), 32'd0);
        chk("rst.halted", 32'(halted), 32'd0);
        chk("rst.stall_cnt", stall_cnt, 32'd0);
        chk("rst.redirect_cnt", redirect_cnt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();

        exp_stall = 0;
        exp_redir = 0;
        foreach (vecs[i]) begin
            set_in(vecs[i].memread, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].uses_rs2,
                   vecs[i].redirect);
            @(negedge clk);
            chk({vecs[i].name, ".pc_write"}, 32'(pc_write), 32'(vecs[i].e_pc));
            if (!vecs[i].redirect)
                chk({vecs[i].name, ".if_id_write"}, 32'(if_id_write), 32'(vecs[i].e_ifid_wr));
            chk({vecs[i].name, ".if_id_flush"}, 32'(if_id_flush), 32'(vecs[i].e_ifid_fl));
            chk({vecs[i].name, ".id_ex_flush"}, 32'(id_ex_flush), 32'(vecs[i].e_idex_fl));
            chk({vecs[i].name, ".ex_mem_flush"}, 32'(ex_mem_flush), 32'(vecs[i].e_exmem_fl));
            exp_stall = exp_stall + 32'(vecs[i].e_stall_inc);
            exp_redir = exp_redir + 32'(vecs[i].e_redir_inc);
            tick();
            chk({vecs[i].name, ".stall_cnt"}, stall_cnt, exp_stall);
            chk({vecs[i].name, ".redirect_cnt"}, redirect_cnt, exp_redir);
        end

        // Clear beats a simultaneous increment.
        set_in(1, 5'd5, 5'd5, 5'd0, 0, 1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        chk("clr.stall_cnt", stall_cnt, 32'd0);
        chk("clr.redirect_cnt", redirect_cnt, 32'd0);

        // Halt: RUN cycle, three drain cycles, then halted.
        halt_req = 1'b1;
        @(negedge clk);
        chk("halt.run_pc_write", 32'(pc_write), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk_freeze($sformatf("halt.drain%0d", i));
            chk($sformatf("halt.drain%0d.halted", i), 32'(halted), 32'd0);
            tick();
        end
        chk("halt.halted", 32'(halted), 32'd1);
        chk_freeze("halt.frozen");

        // Single step.
        tick();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        @(negedge clk);
        chk("step.pc_write", 32'(pc_write), 32'd1);
        chk("step.if_id_write", 32'(if_id_write), 32'd1);
        chk("step.id_ex_flush", 32'(id_ex_flush), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk_freeze($sformatf("step.drain%0d", i));
            chk($sformatf("step.drain%0d.halted", i), 32'(halted), 32'd0);
            tick();
        end
        chk("step.rehalted", 32'(halted), 32'd1);

        // Step held by a load-use hazard.
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        set_in(1, 5'd9, 5'd9, 5'd0, 0, 0);
        chk_freeze("steplu.stall");
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("steplu.issue_pc_write", 32'(pc_write), 32'd1);
        chk("steplu.issue_id_ex_flush", 32'(id_ex_flush), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) tick();
        chk("steplu.rehalted", 32'(halted), 32'd1);

        // Release halt: RUN and halted low next cycle.
        halt_req = 1'b0;
        tick();
        chk("release.halted", 32'(halted), 32'd0);
        @(negedge clk);
        chk("release.pc_write", 32'(pc_write), 32'd1);
        tick();

        // Halt aborted mid-drain.
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk_freeze("abort.drain");
        tick();
        @(negedge clk);
        chk("abort.pc_write", 32'(pc_write), 32'd1);
        tick();

        // Reset in DRAIN with counters at 12 and 4.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        set_in(1, 5'd3, 5'd3, 5'd0, 0, 0);
        for (int i = 0; i < 12; i++) tick();
        set_in(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) tick();
        set_in(0, 0, 0, 0, 0, 0);
        chk("pre_rst.stall_cnt", stall_cnt, 32'd12);
        chk("pre_rst.redirect_cnt", redirect_cnt, 32'd4);
        halt_req = 1'b1;
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("midrst.pc_write", 32'(pc_write), 32'd0);
        chk("midrst.id_ex_flush", 32'(id_ex_flush), 32'd0);
        chk("midrst.halted", 32'(halted), 32'd0);
        chk("midrst.stall_cnt", stall_cnt, 32'd0);
        chk("midrst.redirect_cnt", redirect_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        halt_req = 1'b0;
        tick();
        @(negedge clk);
        chk("postrst.pc_write", 32'(pc_write), 32'd1);
        chk("postrst.if_id_write", 32'(if_id_write), 32'd1);
        chk("postrst.halted", 32'(halted), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
